// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider. It produces one quotient bit per clock
// and raises a one-cycle done pulse when the results are ready.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             geq;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepDvd;

    // One restoring step. The dividend register doubles as the quotient
    // shift register, and the trial value has an extra bit so that large
    // divisors cannot overflow.
    always_comb begin
        trial   = {rem_q, dvd_q[WIDTH-1]};
        diff    = trial - {1'b0, dsr_q};
        geq     = (trial >= {1'b0, dsr_q});
        stepRem = geq ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        stepDvd = {dvd_q[WIDTH-2:0], geq};
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dsr_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            RUN: begin
                dvd_d = stepDvd;
                rem_d = stepRem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quotient_d  = stepDvd;
                    remainder_d = stepRem;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL provide port clk  input  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL provide port start  input  1: request a new division; sampled only in IDLE.
REQ-005 SHALL provide port dividend  input  WIDTH: unsigned numerator, sampled on the accepting edge.
REQ-006 SHALL provide port divisor  input  WIDTH: unsigned denominator, sampled on the accepting edge.
REQ-007 SHALL provide port busy  output  1: high while in RUN or DONE.
REQ-008 SHALL provide port done  output  1: single-cycle pulse; results are valid.
REQ-009 SHALL provide port quotient  output  WIDTH: registered quotient.
REQ-010 SHALL provide port remainder  output  WIDTH: registered remainder.
REQ-011 SHALL provide port div_by_zero  output  1: registered flag set when the last completed division had divisor 0.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 IDLE with start=1 and divisor!=0 SHALL latch both operands, clear the partial remainder and bit counter, and go to RUN on that edge.
REQ-014 IDLE with start=1 and divisor=0 SHALL go directly to DONE on that edge, loading quotient=all ones, remainder=dividend and div_by_zero=1.
REQ-015 RUN SHALL use restoring division, one quotient bit per edge, MSB first: shift {partial remainder, dividend bit} left, compare with the divisor, subtract if greater or equal, and shift in a 1, else shift in a 0.
REQ-016 The partial-remainder compare/subtract SHALL be WIDTH+1 bits wide, so no overflow occurs for divisor values above 2^(WIDTH-1).
REQ-017 RUN SHALL last exactly WIDTH edges; the WIDTH-th RUN edge SHALL load quotient, remainder and div_by_zero=0, and move to DONE.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 Latency for a nonzero divisor SHALL be WIDTH+1: done is high in the cycle after WIDTH+1 rising edges counted from the accepting edge.
REQ-020 Latency for divide-by-zero SHALL be 1: done is high in the cycle immediately after the accepting edge.
REQ-021 start SHALL be ignored in RUN and DONE; no queuing; operands are not resampled.
REQ-022 quotient, remainder and div_by_zero SHALL change only on the edge entering DONE, and SHALL hold until the next completion or reset.
REQ-023 dividend and divisor inputs SHALL be don't-care after the accepting edge; changes to them SHALL not affect the result.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for all nonzero divisors, including dividend < divisor (quotient 0) and divisor 1.
REQ-025 done SHALL never be high in two consecutive cycles.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the internal counter and registers.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 rst asserted mid-RUN SHALL abort the division with no done pulse.
REQ-029 A start presented in the first cycle after rst deasserts SHALL be accepted normally.

Verification (WIDTH=32)
REQ-030 The bench SHALL cover: 100/7 -> quotient=14, remainder=2, div_by_zero=0, done one cycle, 33 edges after the accepting edge.
REQ-031 The bench SHALL cover: 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0; and 0xFFFFFFFF/0x80000001 -> quotient=1, remainder=0x7FFFFFFE.
REQ-032 The bench SHALL cover: 3/10 -> quotient=0, remainder=3.
REQ-033 The bench SHALL cover: 5/0 -> done in the next cycle, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; then 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-034 The bench SHALL cover: start 100/7 accepted, then start 50/5 pulsed at edge 10 -> ignored, result 14 r 2, exactly one done pulse.
REQ-035 The bench SHALL cover: start 1000/3, rst at edge 15 -> no done, outputs zero; fresh 1000/3 -> quotient=333, remainder=1.
